// File: rtl/br_predict_gshare_if.sv
// Fetch/resolve port bundle for br_predict_gshare.
//   master : pipeline side; drives fetch and update fields, observes prediction
//            and statistics outputs.
//   slave  : predictor side.
// Fetch : i_fetch_pc, i_fetch_en -> o_pred_hit/taken/target/pht_idx/ghr
// Update: i_upd_en, i_upd_is_jump, i_upd_pc, i_upd_taken, i_upd_target,
//         i_upd_pht_idx, i_upd_ghr, i_upd_mispred
// Stats : o_branch_cnt, o_mispred_cnt
interface br_predict_gshare_if #(
  parameter int PHT_IDX_W = 8,
  parameter int GHR_W     = 8,
  parameter int CNT_W     = 32
);
  logic [31:0]          i_fetch_pc;
  logic                 i_fetch_en;
  logic                 o_pred_hit;
  logic                 o_pred_taken;
  logic [31:0]          o_pred_target;
  logic [PHT_IDX_W-1:0] o_pred_pht_idx;
  logic [GHR_W-1:0]     o_pred_ghr;
  logic                 i_upd_en;
  logic                 i_upd_is_jump;
  logic [31:0]          i_upd_pc;
  logic                 i_upd_taken;
  logic [31:0]          i_upd_target;
  logic [PHT_IDX_W-1:0] i_upd_pht_idx;
  logic [GHR_W-1:0]     i_upd_ghr;
  logic                 i_upd_mispred;
  logic [CNT_W-1:0]     o_branch_cnt;
  logic [CNT_W-1:0]     o_mispred_cnt;

  modport master (
    output i_fetch_pc, i_fetch_en,
    output i_upd_en, i_upd_is_jump, i_upd_pc, i_upd_taken, i_upd_target,
    output i_upd_pht_idx, i_upd_ghr, i_upd_mispred,
    input  o_pred_hit, o_pred_taken, o_pred_target, o_pred_pht_idx, o_pred_ghr,
    input  o_branch_cnt, o_mispred_cnt
  );

  modport slave (
    input  i_fetch_pc, i_fetch_en,
    input  i_upd_en, i_upd_is_jump, i_upd_pc, i_upd_taken, i_upd_target,
    input  i_upd_pht_idx, i_upd_ghr, i_upd_mispred,
    output o_pred_hit, o_pred_taken, o_pred_target, o_pred_pht_idx, o_pred_ghr,
    output o_branch_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/br_predict_gshare.sv
// Gshare branch predictor: tagged BTB, PHT of 2-bit counters indexed by
// PC ^ GHR, speculative GHR with checkpoint recovery, saturating statistics.
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_rst_n : asynchronous active-low reset
//   bp      : br_predict_gshare_if.slave (fetch lookup, EX update, counters)
module br_predict_gshare #(
  parameter int         BTB_IDX_W = 6,
  parameter int         TAG_W     = 8,
  parameter int         PHT_IDX_W = 8,
  parameter int         GHR_W     = 8,
  parameter logic [1:0] CTR_INIT  = 2'b01,
  parameter int         CNT_W     = 32
) (
  input logic              i_clk,
  input logic              i_rst_n,
  br_predict_gshare_if.slave bp
);

  if (GHR_W < 1 || GHR_W > PHT_IDX_W) begin : g_bad_ghr_w
    $error("br_predict_gshare: GHR_W must be in 1..PHT_IDX_W");
  end

  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;

  logic [BTB_N-1:0] btb_valid;
  logic [BTB_N-1:0] btb_jump;
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [29:0]      btb_tgt [BTB_N];
  logic [1:0]       pht     [PHT_N];
  logic [GHR_W-1:0] ghr;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  logic [BTB_IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic [PHT_IDX_W-1:0] f_pht_idx;
  logic                 f_hit, f_taken, f_is_jump;
  logic                 upd_recover;

  // Shift a direction bit into history; the shift form stays legal for GHR_W == 1.
  function automatic logic [GHR_W-1:0] ghr_push(input logic [GHR_W-1:0] h, input logic b);
    return (h << 1) | GHR_W'(b);
  endfunction

  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign f_idx     = bp.i_fetch_pc[BTB_IDX_W+1:2];
  assign f_tag     = bp.i_fetch_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign u_idx     = bp.i_upd_pc[BTB_IDX_W+1:2];
  assign u_tag     = bp.i_upd_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign f_pht_idx = bp.i_fetch_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);

  assign f_hit     = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign f_is_jump = btb_jump[f_idx];
  assign f_taken   = f_hit && (f_is_jump || pht[f_pht_idx][1]);

  assign bp.o_pred_hit     = f_hit;
  assign bp.o_pred_taken   = f_taken;
  assign bp.o_pred_target  = f_hit ? {btb_tgt[f_idx], 2'b00} : 32'h0;
  assign bp.o_pred_pht_idx = f_pht_idx;
  assign bp.o_pred_ghr     = ghr;
  assign bp.o_branch_cnt   = branch_cnt;
  assign bp.o_mispred_cnt  = mispred_cnt;

  assign upd_recover = bp.i_upd_en && bp.i_upd_mispred;

  // Recovery from the carried checkpoint overrides the speculative shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ghr <= '0;
    end else if (upd_recover) begin
      ghr <= bp.i_upd_is_jump ? bp.i_upd_ghr : ghr_push(bp.i_upd_ghr, bp.i_upd_taken);
    end else if (bp.i_fetch_en && f_hit && !f_is_jump) begin
      ghr <= ghr_push(ghr, f_taken);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= CTR_INIT;
    end else if (bp.i_upd_en && !bp.i_upd_is_jump) begin
      pht[bp.i_upd_pht_idx] <= ctr_sat(pht[bp.i_upd_pht_idx], bp.i_upd_taken);
    end
  end

  // Only taken outcomes allocate; a not-taken branch never touches the BTB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btb_valid <= '0;
    end else if (bp.i_upd_en && bp.i_upd_taken) begin
      btb_valid[u_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is qualified by btb_valid.
  always_ff @(posedge i_clk) begin
    if (bp.i_upd_en && bp.i_upd_taken) begin
      btb_tag[u_idx]  <= u_tag;
      btb_tgt[u_idx]  <= bp.i_upd_target[31:2];
      btb_jump[u_idx] <= bp.i_upd_is_jump;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (bp.i_upd_en) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      if (bp.i_upd_mispred && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bp.i_fetch_pc, bp.i_upd_pc, bp.i_upd_target[1:0]};

endmodule

// File: tb/tb_br_predict_gshare.sv
module tb_br_predict_gshare;

  localparam int PHT_IDX_W = 8;
  localparam int GHR_W     = 8;
  localparam int CNT_W     = 32;

  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  br_predict_gshare_if #(.PHT_IDX_W(PHT_IDX_W), .GHR_W(GHR_W), .CNT_W(CNT_W)) bp ();
  br_predict_gshare_if #(.PHT_IDX_W(8), .GHR_W(1), .CNT_W(4)) bs ();

  br_predict_gshare u_dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bp(bp));
  br_predict_gshare #(.GHR_W(1), .CNT_W(4)) u_small (.i_clk(i_clk), .i_rst_n(i_rst_n), .bp(bs));

  int n_vec = 0;
  int n_err = 0;

  // Reference state, kept as plain values per entry
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int unsigned m_tgt   [64];
  bit          m_jump  [64];
  int          m_pht   [256];
  int unsigned m_ghr, m_br, m_mp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 0; m_br = 0; m_mp = 0;
  endtask

  function automatic int unsigned b_idx(input int unsigned pc);  return (pc / 4) % 64;  endfunction
  function automatic int unsigned b_tag(input int unsigned pc);  return (pc / 256) % 256; endfunction
  function automatic int unsigned p_idx(input int unsigned pc);  return ((pc / 4) ^ m_ghr) % 256; endfunction
  function automatic bit m_hit(input int unsigned pc);
    return m_valid[b_idx(pc)] && m_tag[b_idx(pc)] == b_tag(pc);
  endfunction
  function automatic bit m_taken(input int unsigned pc);
    return m_hit(pc) && (m_jump[b_idx(pc)] || m_pht[p_idx(pc)] >= 2);
  endfunction

  task automatic check_outputs(input string pfx);
    int unsigned pc;
    pc = bp.i_fetch_pc;
    chk({pfx, ".hit"},    bp.o_pred_hit,     m_hit(pc));
    chk({pfx, ".taken"},  bp.o_pred_taken,   m_taken(pc));
    chk({pfx, ".target"}, bp.o_pred_target,  m_hit(pc) ? m_tgt[b_idx(pc)] : 0);
    chk({pfx, ".phtidx"}, bp.o_pred_pht_idx, p_idx(pc));
    chk({pfx, ".ghr"},    bp.o_pred_ghr,     m_ghr);
    chk({pfx, ".brcnt"},  bp.o_branch_cnt,   m_br);
    chk({pfx, ".mpcnt"},  bp.o_mispred_cnt,  m_mp);
  endtask

  // Apply one rising edge of the specified behaviour to the reference state.
  task automatic model_step();
    int unsigned pc, up, ui, nghr;
    bit hit, tk;
    pc   = bp.i_fetch_pc;
    up   = bp.i_upd_pc;
    hit  = m_hit(pc);
    tk   = m_taken(pc);
    nghr = m_ghr;
    if (bp.i_upd_en && bp.i_upd_mispred)
      nghr = bp.i_upd_is_jump ? bp.i_upd_ghr : ((bp.i_upd_ghr * 2) + bp.i_upd_taken) % 256;
    else if (bp.i_fetch_en && hit && !m_jump[b_idx(pc)])
      nghr = ((m_ghr * 2) + tk) % 256;
    if (bp.i_upd_en) begin
      if (!bp.i_upd_is_jump) begin
        ui = bp.i_upd_pht_idx;
        if (bp.i_upd_taken) m_pht[ui] = (m_pht[ui] < 3) ? m_pht[ui] + 1 : 3;
        else                m_pht[ui] = (m_pht[ui] > 0) ? m_pht[ui] - 1 : 0;
      end
      if (bp.i_upd_taken) begin
        m_valid[b_idx(up)] = 1;
        m_tag[b_idx(up)]   = b_tag(up);
        m_tgt[b_idx(up)]   = bp.i_upd_target & 32'hFFFF_FFFC;
        m_jump[b_idx(up)]  = bp.i_upd_is_jump;
      end
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (bp.i_upd_mispred && m_mp != 32'hFFFF_FFFF) m_mp++;
    end
    m_ghr = nghr;
  endtask

  task automatic do_cycle(input string pfx);
    @(negedge i_clk);
    check_outputs(pfx);
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic set_fetch(input logic [31:0] pc, input logic en);
    bp.i_fetch_pc = pc;
    bp.i_fetch_en = en;
  endtask

  task automatic set_upd(input logic en, input logic jmp, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic [7:0] pidx, input logic [7:0] g,
                         input logic mis);
    bp.i_upd_en = en; bp.i_upd_is_jump = jmp; bp.i_upd_pc = pc; bp.i_upd_taken = tk;
    bp.i_upd_target = tgt; bp.i_upd_pht_idx = pidx; bp.i_upd_ghr = g; bp.i_upd_mispred = mis;
  endtask

  task automatic async_reset();
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    bp.i_fetch_en = 0;
    i_rst_n = 0;
    #1;
    chk("rst.hit",    bp.o_pred_hit,    0);
    chk("rst.taken",  bp.o_pred_taken,  0);
    chk("rst.target", bp.o_pred_target, 0);
    chk("rst.ghr",    bp.o_pred_ghr,    0);
    chk("rst.brcnt",  bp.o_branch_cnt,  0);
    chk("rst.mpcnt",  bp.o_mispred_cnt, 0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1;
    @(posedge i_clk);
    #1;
  endtask

  logic [31:0] pool [8];

  initial begin
    pool[0] = 32'h100;  pool[1] = 32'h4100; pool[2] = 32'h80;   pool[3] = 32'h84;
    pool[4] = 32'h600;  pool[5] = 32'h1000; pool[6] = 32'h1104; pool[7] = 32'h2080;
    i_rst_n = 0;
    set_fetch(32'h100, 0);
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    bs.i_fetch_pc = 0; bs.i_fetch_en = 0;
    bs.i_upd_en = 0; bs.i_upd_is_jump = 0; bs.i_upd_pc = 0; bs.i_upd_taken = 0;
    bs.i_upd_target = 0; bs.i_upd_pht_idx = 0; bs.i_upd_ghr = 0; bs.i_upd_mispred = 0;
    model_reset();
    #3;
    chk("init.hit",    bp.o_pred_hit,     0);
    chk("init.taken",  bp.o_pred_taken,   0);
    chk("init.target", bp.o_pred_target,  0);
    chk("init.phtidx", bp.o_pred_pht_idx, 8'h40);
    chk("init.ghr",    bp.o_pred_ghr,     0);
    @(negedge i_clk);
    i_rst_n = 1;
    @(posedge i_clk);
    #1;

    // JAL allocation, visible one cycle later
    set_upd(1, 1, 32'h100, 1, 32'h200, 0, 0, 0);
    do_cycle("jal_upd");
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    set_fetch(32'h100, 1);
    #1;
    chk("jal.hit",    bp.o_pred_hit,    1);
    chk("jal.taken",  bp.o_pred_taken,  1);
    chk("jal.target", bp.o_pred_target, 32'h200);
    do_cycle("jal_fetch");
    chk("jal.ghr_hold", bp.o_pred_ghr, 0);

    // Counter walk at 0x80 with fixed PHT index
    set_fetch(32'h80, 0);
    for (int i = 0; i < 3; i++) begin
      set_upd(1, 0, 32'h80, 1, 32'h300, 8'h20, 0, 0);
      do_cycle("ctr_up");
    end
    for (int i = 0; i < 3; i++) begin
      set_upd(1, 0, 32'h80, 0, 32'h300, 8'h20, 0, 0);
      do_cycle("ctr_dn");
    end
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ctr0.hit",   bp.o_pred_hit,   1);
    chk("ctr0.taken", bp.o_pred_taken, 0);

    // Aliasing on BTB index 0
    set_upd(1, 0, 32'h4100, 1, 32'h500, 8'h40, 0, 0);
    do_cycle("alias_upd");
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    set_fetch(32'h100, 0);
    #1;
    chk("alias.old_miss", bp.o_pred_hit, 0);
    set_fetch(32'h4100, 0);
    #1;
    chk("alias.new_hit", bp.o_pred_hit, 1);
    do_cycle("alias_fetch");

    // Speculative GHR fill and same-cycle recovery
    async_reset();
    set_fetch(32'h80, 0);
    set_upd(1, 0, 32'h80, 1, 32'h300, 8'h20, 0, 0); do_cycle("ghr_setup");
    set_upd(1, 0, 32'h80, 1, 32'h300, 8'h21, 0, 0); do_cycle("ghr_setup");
    set_upd(1, 0, 32'h80, 1, 32'h300, 8'h23, 0, 0); do_cycle("ghr_setup");
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    set_fetch(32'h80, 1);
    for (int i = 0; i < 3; i++) do_cycle("ghr_spec");
    chk("ghr.fill", bp.o_pred_ghr, 8'h07);
    set_upd(1, 0, 32'h90, 0, 32'h0, 8'h55, 8'h01, 1);
    do_cycle("ghr_recover");
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    set_fetch(32'h80, 0);
    #1;
    chk("ghr.recover", bp.o_pred_ghr,    8'h02);
    chk("ghr.mpcnt",   bp.o_mispred_cnt, 1);
    chk("ghr.brcnt",   bp.o_branch_cnt,  4);

    // Not-taken miss must not allocate
    set_upd(1, 0, 32'h600, 0, 32'h700, 8'h10, 0, 0);
    do_cycle("nt_miss");
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);
    set_fetch(32'h600, 0);
    #1;
    chk("nt_miss.hit", bp.o_pred_hit, 0);

    // Randomised traffic with one mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      set_fetch(($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)],
                1'($urandom_range(0, 1)));
      set_upd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), pool[$urandom_range(0, 7)],
              1'($urandom_range(0, 1)), $urandom, 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 3) == 0));
      if (bp.i_upd_is_jump) bp.i_upd_taken = 1;
      do_cycle("rand");
      if (n == 1500) async_reset();
    end
    set_upd(0, 0, 0, 0, 0, 0, 0, 0);

    // Narrow instance: counter saturation and single-bit history
    @(negedge i_clk);
    for (int i = 0; i < 20; i++) begin
      bs.i_upd_en = 1; bs.i_upd_is_jump = 0; bs.i_upd_pc = 32'h40; bs.i_upd_taken = 1;
      bs.i_upd_target = 32'h80; bs.i_upd_pht_idx = 8'(i); bs.i_upd_ghr = 0;
      bs.i_upd_mispred = 1'(i % 2);
      @(negedge i_clk);
    end
    bs.i_upd_en = 0;
    bs.i_upd_mispred = 0;
    #1;
    chk("small.brcnt_sat", bs.o_branch_cnt,  4'hF);
    chk("small.mpcnt",     bs.o_mispred_cnt, 4'hA);
    chk("small.ghr1",      bs.o_pred_ghr,    1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/br_predict_gshare.md
Name: br_predict_gshare

Overview:
- Parametrised gshare branch predictor for the pipelined RV32I core.
- Successor to the direct-mapped 2-bit/BTB predictor. Adds a tagged BTB, a separate pattern history table (PHT) of 2-bit counters indexed by PC XOR global history, and a speculative global history register (GHR) with checkpoint recovery.
- IF side does a combinational lookup on the fetch PC. EX side writes resolved outcome and redirect info back.
- Includes saturating performance counters for branch/mispredict statistics.

Parameters:
- BTB_IDX_W, 6, log2 of BTB entries (64).
- TAG_W, 8, BTB tag width taken from PC above the index bits.
- PHT_IDX_W, 8, log2 of PHT entries (256).
- GHR_W, 8, global history length; legal range 1..PHT_IDX_W.
- CTR_INIT, 2'b01, PHT counter reset value (weakly not-taken).
- CNT_W, 32, performance counter width.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_fetch_pc  in  32  PC being fetched (IF).
- i_fetch_en  in  1  IF advances this cycle (low = stall).
- o_pred_hit  out  1  BTB tag hit on i_fetch_pc.
- o_pred_taken  out  1  predict redirect to o_pred_target.
- o_pred_target  out  32  predicted target; 0 on miss.
- o_pred_pht_idx  out  PHT_IDX_W  PHT index used, carried down pipeline.
- o_pred_ghr  out  GHR_W  GHR checkpoint before this fetch's shift, carried down pipeline.
- i_upd_en  in  1  EX resolved a branch/jump this cycle.
- i_upd_is_jump  in  1  1 = JAL/JALR, 0 = conditional branch.
- i_upd_pc  in  32  PC of resolved instruction.
- i_upd_taken  in  1  actual direction (1 for jumps).
- i_upd_target  in  32  actual target (ALU result).
- i_upd_pht_idx  in  PHT_IDX_W  PHT index carried from IF.
- i_upd_ghr  in  GHR_W  GHR checkpoint carried from IF.
- i_upd_mispred  in  1  EX detected direction or target mispredict.
- o_branch_cnt  out  CNT_W  resolved control instructions.
- o_mispred_cnt  out  CNT_W  mispredictions.

Behaviour:
- Fields:
  - BTB index = pc[BTB_IDX_W+1:2].
  - BTB tag = pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2].
  - BTB entry = {valid, tag, target[31:2], is_jump}.
- Lookup (combinational from registered state, zero latency):
  - hit = entry.valid & tag match.
  - pht_idx = pc[PHT_IDX_W+1:2] XOR zero-extended GHR (GHR in LSBs).
  - o_pred_taken = hit & (is_jump | PHT[pht_idx][1]).
  - o_pred_target = hit ? {target,2'b00} : 0.
  - o_pred_pht_idx and o_pred_ghr are always driven, even on miss.
- Speculative GHR:
  - On i_fetch_en & hit & !is_jump: GHR <= {GHR[GHR_W-2:0], o_pred_taken}.
  - Jumps and misses do not shift.
- Recovery:
  - On i_upd_en & i_upd_mispred & !i_upd_is_jump: GHR <= {i_upd_ghr[GHR_W-2:0], i_upd_taken}.
  - On i_upd_en & i_upd_mispred & i_upd_is_jump: GHR <= i_upd_ghr.
  - Recovery has priority over a same-cycle speculative shift.
- PHT update:
  - On i_upd_en & !i_upd_is_jump, PHT[i_upd_pht_idx] saturating counter: taken increments (max 2'b11), not-taken decrements (min 2'b00).
- BTB update on i_upd_en:
  - Taken (branch or jump): write {1, tag, target[31:2], is_jump} at index. This allocates or overwrites on tag conflict.
  - Not-taken branch: BTB unchanged, including on a miss (no allocation).
- Same-cycle update and lookup of the same entry: lookup returns pre-update values (no bypass). The new value is visible next cycle.
- Counters:
  - o_branch_cnt += 1 on i_upd_en.
  - o_mispred_cnt += 1 on i_upd_en & i_upd_mispred.
  - Both saturate at all-ones.
- i_upd_mispred without i_upd_en is ignored.
- Reset (asynchronous, any time including mid-stream):
  - All BTB valid = 0; PHT = CTR_INIT; GHR = 0; counters = 0.
  - Therefore o_pred_hit = 0, o_pred_taken = 0, o_pred_target = 0, o_pred_ghr = 0, o_branch_cnt = 0, o_mispred_cnt = 0.
  - After release, the first rising edge may perform updates.
- GHR_W = 1 and GHR_W = PHT_IDX_W must both work. Generate elaboration error outside 1..PHT_IDX_W.

Test Plan:
- Reset then lookup 0x0000_0100 -> hit=0, taken=0, target=0, pht_idx=0x40, ghr=0. Assert reset mid-run -> all outputs 0 asynchronously.
- Update JAL pc=0x100, target=0x200, taken=1 -> next cycle lookup 0x100: hit=1, taken=1, target=0x200. GHR unchanged on fetch.
- Branch at 0x80 resolved taken 3x with fixed pht_idx -> counter 01->10->11->11. Lookup predicts taken after first update. Then 3 not-taken -> 11->10->01->00; taken=0 while hit=1.
- Aliasing: pc 0x100 entry valid, update taken pc 0x4100 (same index, different tag) -> lookup 0x100 miss, 0x4100 hit.
- GHR: fetch 3 taken-predicted branches with i_fetch_en=1 -> GHR=0x07. Same-cycle mispredict update with i_upd_ghr=0x01, taken=0 -> GHR=0x02. Speculative shift dropped; o_mispred_cnt=1.
- Saturation: force CNT_W=4, issue 20 updates -> o_branch_cnt holds 0xF. Not-taken miss update -> BTB unchanged.
